// File: rtl/set_assoc_cache.sv
// set_assoc_cache: a 2-way set-associative, write-back, write-allocate cache
// that sits between a single-word CPU port and a line-wide memory port.
//
// Parameters
//   WORD_W : CPU word width and address width
//   IDX_W  : set-index bits (2**IDX_W sets)
//   OFF_W  : word-offset bits (2**OFF_W words per line)
//
// Ports
//   clk, reset_n             : clock, synchronous active-low reset
//   cpu_rd, cpu_wr           : CPU request (both high is a write)
//   cpu_addr, cpu_wdata      : CPU word address and write data
//   cpu_rdata, cpu_ready     : read data and request-complete strobe
//   mem_rd, mem_wr           : memory line read / write strobes
//   mem_addr, mem_wdata      : line-aligned address, write-back line
//   mem_rdata, mem_ready     : fill line, memory-complete strobe
//   hit_cnt/miss_cnt/wb_cnt  : statistics counters
//   fsm_state                : current controller state (IDLE=0 WB=1 FILL=2 RESP=3)
//
// Handshakes: the CPU holds its request stable while cpu_ready=0 and the
// request completes in the cycle cpu_ready=1. The cache holds mem_rd or
// mem_wr (never both) with stable address/data until a cycle where
// mem_ready=1; that cycle completes the memory transaction.
//
// Build option: define CACHE_STATS_EN to build saturating hit/miss/
// write-back counters; otherwise the counters read as zero.
module set_assoc_cache #(
    parameter int WORD_W = 16,
    parameter int IDX_W  = 2,
    parameter int OFF_W  = 2,
    localparam int TAG_W  = WORD_W - IDX_W - OFF_W,
    localparam int LINE_W = WORD_W << OFF_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cpu_rd,
    input  logic              cpu_wr,
    input  logic [WORD_W-1:0] cpu_addr,
    input  logic [WORD_W-1:0] cpu_wdata,
    output logic [WORD_W-1:0] cpu_rdata,
    output logic              cpu_ready,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [WORD_W-1:0] mem_addr,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic [15:0]       hit_cnt,
    output logic [15:0]       miss_cnt,
    output logic [15:0]       wb_cnt,
    output logic [1:0]        fsm_state
);
    localparam int SETS = 1 << IDX_W;

    typedef enum logic [1:0] {IDLE = 2'd0, WB = 2'd1, FILL = 2'd2, RESP = 2'd3} state_t;
    state_t state, next_state;

    logic [1:0][SETS-1:0] valid_q;
    logic [1:0][SETS-1:0] dirty_q;
    logic [SETS-1:0]      lru_q;      // names the least-recently-used way
    logic [TAG_W-1:0]     tag_q  [2][SETS];
    logic [LINE_W-1:0]    line_q [2][SETS];

    // Miss context captured in IDLE and used through WB/FILL/RESP
    logic [WORD_W-1:0] lat_addr;
    logic [WORD_W-1:0] lat_wdata;
    logic              lat_wr;
    logic              lat_way;

    logic [IDX_W-1:0] idx, lat_idx;
    logic [TAG_W-1:0] tag, lat_tag;
    logic [OFF_W-1:0] off, lat_off;
    assign idx     = cpu_addr[OFF_W +: IDX_W];
    assign tag     = cpu_addr[WORD_W-1 -: TAG_W];
    assign off     = cpu_addr[OFF_W-1:0];
    assign lat_idx = lat_addr[OFF_W +: IDX_W];
    assign lat_tag = lat_addr[WORD_W-1 -: TAG_W];
    assign lat_off = lat_addr[OFF_W-1:0];

    logic hit0, hit1, hit, hit_way, victim_way, req;
    assign hit0    = valid_q[0][idx] && (tag_q[0][idx] == tag);
    assign hit1    = valid_q[1][idx] && (tag_q[1][idx] == tag);
    assign hit     = hit0 || hit1;
    assign hit_way = hit1;
    assign req     = cpu_rd || cpu_wr;
    // Fill an empty way first (way0 before way1), otherwise evict the LRU way
    assign victim_way = !valid_q[0][idx] ? 1'b0 :
                        !valid_q[1][idx] ? 1'b1 : lru_q[idx];

    logic idle_hit, idle_miss, wb_done, fill_done;
    assign idle_hit  = (state == IDLE) && req && hit;
    assign idle_miss = (state == IDLE) && req && !hit;
    assign wb_done   = (state == WB) && mem_ready;
    assign fill_done = (state == FILL) && mem_ready;

    assign fsm_state = state;

    always_ff @(posedge clk) begin
        if (!reset_n) state <= IDLE;
        else          state <= next_state;
    end

    always_comb begin
        next_state = state;
        cpu_ready  = 1'b0;
        cpu_rdata  = '0;
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        case (state)
            IDLE: begin
                if (!req) begin
                    cpu_ready = 1'b1;
                end else if (hit) begin
                    cpu_ready = 1'b1;
                    if (!cpu_wr) cpu_rdata = line_q[hit_way][idx][int'(off)*WORD_W +: WORD_W];
                end else if (valid_q[victim_way][idx] && dirty_q[victim_way][idx]) begin
                    next_state = WB;
                end else begin
                    next_state = FILL;
                end
            end
            WB: begin
                mem_wr    = 1'b1;
                mem_addr  = {tag_q[lat_way][lat_idx], lat_idx, {OFF_W{1'b0}}};
                mem_wdata = line_q[lat_way][lat_idx];
                if (mem_ready) next_state = FILL;
            end
            FILL: begin
                mem_rd   = 1'b1;
                mem_addr = {lat_tag, lat_idx, {OFF_W{1'b0}}};
                if (mem_ready) next_state = RESP;
            end
            RESP: begin
                cpu_ready  = 1'b1;
                if (!lat_wr) cpu_rdata = line_q[lat_way][lat_idx][int'(lat_off)*WORD_W +: WORD_W];
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Tag and line storage are not reset: valid bits gate every use of them.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            valid_q   <= '0;
            dirty_q   <= '0;
            lru_q     <= '0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_wr    <= 1'b0;
            lat_way   <= 1'b0;
        end else begin
            if (idle_hit) begin
                lru_q[idx] <= ~hit_way;
                if (cpu_wr) begin
                    line_q[hit_way][idx][int'(off)*WORD_W +: WORD_W] <= cpu_wdata;
                    dirty_q[hit_way][idx] <= 1'b1;
                end
            end
            if (idle_miss) begin
                lat_addr  <= cpu_addr;
                lat_wdata <= cpu_wdata;
                lat_wr    <= cpu_wr;
                lat_way   <= victim_way;
            end
            if (fill_done) begin
                line_q[lat_way][lat_idx]  <= mem_rdata;
                tag_q[lat_way][lat_idx]   <= lat_tag;
                valid_q[lat_way][lat_idx] <= 1'b1;
                dirty_q[lat_way][lat_idx] <= 1'b0;
            end
            if (state == RESP) begin
                lru_q[lat_idx] <= ~lat_way;
                if (lat_wr) begin
                    line_q[lat_way][lat_idx][int'(lat_off)*WORD_W +: WORD_W] <= lat_wdata;
                    dirty_q[lat_way][lat_idx] <= 1'b1;
                end
            end
        end
    end

`ifdef CACHE_STATS_EN
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
            wb_cnt   <= '0;
        end else begin
            if (idle_hit && hit_cnt != 16'hFFFF)   hit_cnt  <= hit_cnt + 16'd1;
            if (idle_miss && miss_cnt != 16'hFFFF) miss_cnt <= miss_cnt + 16'd1;
            if (wb_done && wb_cnt != 16'hFFFF)     wb_cnt   <= wb_cnt + 16'd1;
        end
    end
`else
    assign hit_cnt  = '0;
    assign miss_cnt = '0;
    assign wb_cnt   = '0;
`endif

endmodule

// File: tb/tb_set_assoc_cache.sv
// Testbench for set_assoc_cache: word-level reference memory plus a line
// memory responder with programmable latency; read data is checked through
// an expected-value queue, latency and memory traffic are checked per test.
module tb_set_assoc_cache;
    localparam int WORD_W = 16;
    localparam int IDX_W  = 2;
    localparam int OFF_W  = 2;
    localparam int LINE_W = WORD_W << OFF_W;
    localparam int WORDS  = 1 << OFF_W;
`ifdef CACHE_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic              clk, reset_n, cpu_rd, cpu_wr, cpu_ready;
    logic [WORD_W-1:0] cpu_addr, cpu_wdata, cpu_rdata, mem_addr;
    logic              mem_rd, mem_wr, mem_ready;
    logic [LINE_W-1:0] mem_wdata, mem_rdata;
    logic [15:0]       hit_cnt, miss_cnt, wb_cnt;
    logic [1:0]        fsm_state;

    set_assoc_cache #(.WORD_W(WORD_W), .IDX_W(IDX_W), .OFF_W(OFF_W)) dut (
        .clk(clk), .reset_n(reset_n), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
        .cpu_ready(cpu_ready), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ready(mem_ready), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt),
        .wb_cnt(wb_cnt), .fsm_state(fsm_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- models and scoreboard ----------------
    int checks = 0;
    int failures = 0;
    int mem_lat = 3;
    int mem_cnt = 0;
    int strobe_err = 0;

    logic [WORD_W-1:0] mem_words [logic [WORD_W-1:0]];
    logic [WORD_W-1:0] ref_words [logic [WORD_W-1:0]];
    logic [WORD_W-1:0] exp_q[$];

    typedef struct {
        bit                wr;
        logic [WORD_W-1:0] addr;
        logic [LINE_W-1:0] data;
    } mem_ev_t;
    mem_ev_t mem_log[$];
    mem_ev_t ev;

    function automatic logic [WORD_W-1:0] dflt_word(input logic [WORD_W-1:0] a);
        return WORD_W'((a * 263) ^ 15450);
    endfunction

    function automatic logic [WORD_W-1:0] mem_word(input logic [WORD_W-1:0] a);
        return mem_words.exists(a) ? mem_words[a] : dflt_word(a);
    endfunction

    function automatic logic [WORD_W-1:0] ref_word(input logic [WORD_W-1:0] a);
        return ref_words.exists(a) ? ref_words[a] : dflt_word(a);
    endfunction

    function automatic logic [LINE_W-1:0] ref_line(input logic [WORD_W-1:0] base);
        logic [LINE_W-1:0] l;
        for (int k = 0; k < WORDS; k++) l[k*WORD_W +: WORD_W] = ref_word(WORD_W'(base + k));
        return l;
    endfunction

    // Memory responder: completes each strobed transaction after mem_lat cycles.
    always @(negedge clk) begin
        mem_ready = 1'b0;
        if (mem_rd && mem_wr) strobe_err++;
        if ((mem_rd || mem_wr) && mem_addr[OFF_W-1:0] != '0) strobe_err++;
        if (mem_rd || mem_wr) begin
            if (mem_cnt >= mem_lat - 1) begin
                mem_ready = 1'b1;
                mem_cnt = 0;
                ev.wr = mem_wr;
                ev.addr = mem_addr;
                if (mem_wr) begin
                    for (int k = 0; k < WORDS; k++)
                        mem_words[WORD_W'(mem_addr + k)] = mem_wdata[k*WORD_W +: WORD_W];
                    ev.data = mem_wdata;
                end else begin
                    for (int k = 0; k < WORDS; k++)
                        mem_rdata[k*WORD_W +: WORD_W] = mem_word(WORD_W'(mem_addr + k));
                    ev.data = mem_rdata;
                end
                mem_log.push_back(ev);
            end else begin
                mem_cnt++;
            end
        end else begin
            mem_cnt = 0;
        end
    end

    // ---------------- driver ----------------
    // Starts at a falling edge with the CPU idle; returns at a falling edge
    // with the CPU idle. cyc counts cycles from request to cpu_ready.
    task automatic cpu_access(input bit wr, input bit both, input logic [WORD_W-1:0] addr,
                              input logic [WORD_W-1:0] wdata, output int cyc);
        logic [WORD_W-1:0] got, exp;
        cpu_wr = wr;
        cpu_rd = !wr || both;
        cpu_addr = addr;
        cpu_wdata = wdata;
        if (wr) ref_words[addr] = wdata;
        else    exp_q.push_back(ref_word(addr));
        cyc = 1;
        #1;
        while (!cpu_ready && cyc < 100) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        if (!cpu_ready) begin
            checks++; failures++;
            $display("FAIL access_timeout addr=%h cycles=%0d required cpu_ready=1", addr, cyc);
        end
        if (!wr) begin
            exp = exp_q.pop_front();
            got = cpu_rdata;
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL read_data addr=%h got=%h exp=%h", addr, got, exp);
            end
        end
        @(negedge clk);
        cpu_rd = 1'b0;
        cpu_wr = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        #1;
        checks++;
        if ({cpu_ready, mem_rd, mem_wr} !== 3'b100) begin
            failures++;
            $display("FAIL reset_strobes got=%b exp=100", {cpu_ready, mem_rd, mem_wr});
        end
        checks++;
        if ({mem_addr, mem_wdata, cpu_rdata} !== '0) begin
            failures++;
            $display("FAIL reset_data got addr=%h wdata=%h rdata=%h exp 0", mem_addr, mem_wdata, cpu_rdata);
        end
        checks++;
        if ({hit_cnt, miss_cnt, wb_cnt, fsm_state} !== '0) begin
            failures++;
            $display("FAIL reset_counters got=%h/%h/%h state=%0d exp 0", hit_cnt, miss_cnt, wb_cnt, fsm_state);
        end
        @(negedge clk);
    endtask

    task automatic test_fill_read();
        int cyc;
        mem_lat = 3;
        mem_log.delete();
        cpu_access(1'b0, 1'b0, 16'h0010, '0, cyc);
        checks++;
        if (cyc !== 5) begin failures++; $display("FAIL clean_miss_latency got=%0d exp=5", cyc); end
        checks++;
        if (mem_log.size() != 1 || mem_log[0].wr || mem_log[0].addr !== 16'h0010) begin
            failures++;
            $display("FAIL fill_traffic got events=%0d exp one read at 0010", mem_log.size());
        end
        cpu_access(1'b0, 1'b0, 16'h0012, '0, cyc);
        checks++;
        if (cyc !== 1) begin failures++; $display("FAIL read_hit_latency got=%0d exp=1", cyc); end
    endtask

    task automatic test_write_hit();
        int cyc;
        mem_log.delete();
        cpu_access(1'b1, 1'b0, 16'h0011, 16'h1234, cyc);
        checks++;
        if (cyc !== 1 || mem_log.size() != 0) begin
            failures++;
            $display("FAIL write_hit got cycles=%0d events=%0d exp 1 and 0", cyc, mem_log.size());
        end
        cpu_access(1'b0, 1'b0, 16'h0011, '0, cyc);
    endtask

    task automatic test_lru_victim();
        int cyc;
        cpu_access(1'b0, 1'b0, 16'h0110, '0, cyc);
        cpu_access(1'b0, 1'b0, 16'h0010, '0, cyc);
        mem_log.delete();
        cpu_access(1'b0, 1'b0, 16'h0210, '0, cyc);
        checks++;
        if (cyc !== 5 || mem_log.size() != 1 || mem_log[0].wr || mem_log[0].addr !== 16'h0210) begin
            failures++;
            $display("FAIL lru_victim got cycles=%0d events=%0d exp 5 cycles, one read at 0210", cyc, mem_log.size());
        end
    endtask

    task automatic test_dirty_evict();
        int cyc;
        mem_log.delete();
        cpu_access(1'b0, 1'b0, 16'h0310, '0, cyc);
        checks++;
        if (cyc !== 8) begin failures++; $display("FAIL dirty_miss_latency got=%0d exp=8", cyc); end
        checks++;
        if (mem_log.size() != 2 || !mem_log[0].wr || mem_log[0].addr !== 16'h0010 ||
            mem_log[0].data !== ref_line(16'h0010) || mem_log[1].wr || mem_log[1].addr !== 16'h0310) begin
            failures++;
            $display("FAIL writeback_order got events=%0d exp write 0010 line %h then read 0310",
                     mem_log.size(), ref_line(16'h0010));
        end
        checks++;
        if (wb_cnt !== (STATS ? 16'd1 : 16'd0)) begin
            failures++; $display("FAIL wb_cnt got=%0d exp=%0d", wb_cnt, STATS ? 1 : 0);
        end
        checks++;
        if (hit_cnt !== (STATS ? 16'd4 : 16'd0) || miss_cnt !== (STATS ? 16'd4 : 16'd0)) begin
            failures++; $display("FAIL hit_miss_cnt got=%0d/%0d exp=%0d", hit_cnt, miss_cnt, STATS ? 4 : 0);
        end
        // Written-back data must come back from memory on the next miss
        cpu_access(1'b0, 1'b0, 16'h0011, '0, cyc);
        checks++;
        if (cyc !== 5) begin failures++; $display("FAIL refetch_latency got=%0d exp=5", cyc); end
    endtask

    task automatic test_write_miss();
        int cyc;
        mem_log.delete();
        cpu_access(1'b1, 1'b0, 16'h0444, 16'hBEEF, cyc);
        checks++;
        if (cyc !== 5 || mem_log.size() != 1 || mem_log[0].wr || mem_log[0].addr !== 16'h0444) begin
            failures++;
            $display("FAIL write_allocate got cycles=%0d events=%0d exp 5, one read at 0444", cyc, mem_log.size());
        end
        cpu_access(1'b1, 1'b1, 16'h0446, 16'hCAFE, cyc);
        checks++;
        if (cyc !== 1) begin failures++; $display("FAIL rd_wr_both_latency got=%0d exp=1", cyc); end
        cpu_access(1'b0, 1'b0, 16'h0446, '0, cyc);
        cpu_access(1'b0, 1'b0, 16'h0445, '0, cyc);
        cpu_access(1'b0, 1'b0, 16'h0444, '0, cyc);
    endtask

    task automatic test_reset_during_fill();
        int cyc;
        mem_lat = 3;
        cpu_rd = 1'b1;
        cpu_addr = 16'h0820;
        @(negedge clk);
        #1;
        checks++;
        if (mem_rd !== 1'b1 || fsm_state !== 2'd2) begin
            failures++; $display("FAIL fill_entry got mem_rd=%b state=%0d exp 1 and 2", mem_rd, fsm_state);
        end
        reset_n = 1'b0;
        cpu_rd = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (mem_rd !== 1'b0 || fsm_state !== 2'd0 || cpu_ready !== 1'b1) begin
            failures++;
            $display("FAIL abort_fill got mem_rd=%b state=%0d ready=%b exp 0,0,1", mem_rd, fsm_state, cpu_ready);
        end
        checks++;
        if ({hit_cnt, miss_cnt, wb_cnt} !== '0) begin
            failures++; $display("FAIL abort_counters got=%h/%h/%h exp 0", hit_cnt, miss_cnt, wb_cnt);
        end
        reset_n = 1'b1;
        @(negedge clk);
        mem_log.delete();
        cpu_access(1'b0, 1'b0, 16'h0820, '0, cyc);
        checks++;
        if (cyc !== 5 || mem_log.size() != 1 || mem_log[0].addr !== 16'h0820) begin
            failures++;
            $display("FAIL reread_after_reset got cycles=%0d events=%0d exp 5, one read at 0820", cyc, mem_log.size());
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        logic [WORD_W-1:0] a;
        // Tags 0..3 only, so lines lost to the mid-fill reset are never revisited
        for (int n = 0; n < 80; n++) begin
            mem_lat = $urandom_range(1, 4);
            a = WORD_W'(($urandom_range(0, 3) << (IDX_W + OFF_W)) |
                        $urandom_range(0, (1 << (IDX_W + OFF_W)) - 1));
            cpu_access(1'(($urandom_range(0, 1))), 1'(($urandom_range(0, 1))), a,
                       WORD_W'($urandom_range(0, 65535)), cyc);
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++; $display("FAIL scoreboard_drain got=%0d exp=0", exp_q.size());
        end
    endtask

    task automatic test_protocol();
        checks++;
        if (strobe_err != 0) begin
            failures++; $display("FAIL mem_strobe_rules got=%0d violations exp=0", strobe_err);
        end
    endtask

    initial begin
        reset_n = 1'b0;
        cpu_rd = 1'b0;
        cpu_wr = 1'b0;
        cpu_addr = '0;
        cpu_wdata = '0;
        mem_ready = 1'b0;
        mem_rdata = '0;
        mem_words[16'h0010] = 16'hAAAA; ref_words[16'h0010] = 16'hAAAA;
        mem_words[16'h0011] = 16'hBBBB; ref_words[16'h0011] = 16'hBBBB;
        mem_words[16'h0012] = 16'hCCCC; ref_words[16'h0012] = 16'hCCCC;
        mem_words[16'h0013] = 16'hDDDD; ref_words[16'h0013] = 16'hDDDD;
        test_reset();
        test_fill_read();
        test_write_hit();
        test_lru_victim();
        test_dirty_evict();
        test_write_miss();
        test_reset_during_fill();
        test_back_to_back();
        test_protocol();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
